// File: rtl/fb_port_arbiter_pkg.sv
// rtl/fb_port_arbiter_pkg.sv - shared frame-buffer geometry, widths and grant encodings
package fb_port_arbiter_pkg;

    localparam int FB_WIDTH   = 200;
    localparam int FB_HEIGHT  = 164;
    localparam int FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < FB_DEPTH;
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - display read, pixel writer and RAM signals of the arbiter
interface fb_port_arbiter_if;
    import fb_port_arbiter_pkg::*;

    logic                vga_rd_en;
    logic [ADDR_W-1:0]   vga_rd_addr;
    logic [DATA_W-1:0]   vga_rd_data;
    logic                vga_rd_valid;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                ram_en;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                oob_err;

    modport master (
        output vga_rd_en, vga_rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  vga_rd_data, vga_rd_valid, wr_ready, ram_en, ram_we, ram_addr,
               ram_wdata, fifo_level, oob_err
    );

    modport slave (
        input  vga_rd_en, vga_rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output vga_rd_data, vga_rd_valid, wr_ready, ram_en, ram_we, ram_addr,
               ram_wdata, fifo_level, oob_err
    );

endinterface

// File: rtl/fb_port_arbiter_wr_fifo.sv
// rtl/fb_port_arbiter_wr_fifo.sv - synchronous write queue holding {addr,data} requests
module fb_wr_fifo
    import fb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wr_req_t             push_data,
    input  logic                pop,
    output wr_req_t             head,
    output logic                full,
    output logic                empty,
    output logic [LEVEL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == LEVEL_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LEVEL_W'(push_ok) - LEVEL_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame-buffer arbiter, display reads over queued writes
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
(
    input  logic             clk_25mhz,
    input  logic             rst,
    fb_port_arbiter_if.slave bus
);

    grant_t              grant;
    wr_req_t             head;
    wr_req_t             push_req;
    logic                full;
    logic                empty;
    logic [LEVEL_W-1:0]  level;
    logic                handshake;
    logic                in_range;
    logic                push;
    logic                pop;

    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic [1:0]          rd_pipe;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                oob_q;

    // Out-of-range writes still complete the handshake so the writer never stalls on them.
    assign handshake = bus.wr_valid && bus.wr_ready;
    assign in_range  = addr_in_range(bus.wr_addr);
    assign push      = handshake && in_range;
    assign push_req  = '{addr: bus.wr_addr, data: bus.wr_data};
    assign pop       = (grant == GNT_WR);

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk_25mhz),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        grant = GNT_NONE;
        if (bus.vga_rd_en) begin
            grant = GNT_RD;
        end else if (!empty) begin
            grant = GNT_WR;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_pipe     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            oob_q       <= 1'b0;
        end else begin
            case (grant)
                GNT_RD: begin
                    ram_en_q   <= 1'b1;
                    ram_we_q   <= 1'b0;
                    ram_addr_q <= bus.vga_rd_addr;
                end
                GNT_WR: begin
                    ram_en_q    <= 1'b1;
                    ram_we_q    <= 1'b1;
                    ram_addr_q  <= head.addr;
                    ram_wdata_q <= head.data;
                end
                default: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
            endcase
            // rd_pipe[1] marks the cycle in which ram_rdata carries the requested pixel.
            rd_pipe    <= {rd_pipe[0], (grant == GNT_RD)};
            rd_valid_q <= rd_pipe[1];
            if (rd_pipe[1]) begin
                rd_data_q <= bus.ram_rdata;
            end
            if (handshake && !in_range) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign bus.wr_ready     = !full;
    assign bus.fifo_level   = level;
    assign bus.ram_en       = ram_en_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.vga_rd_valid = rd_valid_q;
    assign bus.vga_rd_data  = rd_data_q;
    assign bus.oob_err      = oob_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed and randomized checks of fb_port_arbiter against a queue model
module tb_fb_port_arbiter;
    import fb_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fb_port_arbiter_if bus ();

    fb_port_arbiter dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #20 clk = ~clk;

    logic [DATA_W-1:0] mem     [FB_DEPTH];
    logic [DATA_W-1:0] ref_mem [FB_DEPTH];

    always @(posedge clk) begin
        if (bus.ram_en && !bus.ram_we) begin
            bus.ram_rdata <= mem[32'(bus.ram_addr)];
        end
        if (bus.ram_en && bus.ram_we) begin
            mem[32'(bus.ram_addr)] <= bus.ram_wdata;
        end
    end

    // Reference model: pending writes as a queue, expected RAM bus and read-return timeline.
    wr_req_t            mq[$];
    logic               m_en, m_we, m_oob;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic               p0_v, p1_v, m_rv;
    logic [DATA_W-1:0]  p0_d, p1_d, m_rd;
    logic               last_acc;

    int checks_total  = 0;
    int checks_passed = 0;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        check("ram_en",       32'(bus.ram_en),       32'(m_en));
        check("ram_we",       32'(bus.ram_we),       32'(m_we));
        check("ram_addr",     32'(bus.ram_addr),     32'(m_addr));
        check("ram_wdata",    32'(bus.ram_wdata),    32'(m_wdata));
        check("fifo_level",   32'(bus.fifo_level),   32'(mq.size()));
        check("wr_ready",     32'(bus.wr_ready),     32'(mq.size() != FIFO_DEPTH));
        check("vga_rd_valid", 32'(bus.vga_rd_valid), 32'(m_rv));
        check("vga_rd_data",  32'(bus.vga_rd_data),  32'(m_rd));
        check("oob_err",      32'(bus.oob_err),      32'(m_oob));
    endtask

    task automatic step();
        wr_req_t w;
        last_acc = 1'b0;
        if (rst) begin
            mq.delete();
            {m_en, m_we, m_oob, p0_v, p1_v, m_rv} = '0;
            m_addr = '0; m_wdata = '0; p0_d = '0; p1_d = '0; m_rd = '0;
        end else begin
            last_acc = bus.wr_valid && (mq.size() < FIFO_DEPTH);
            m_rv = p1_v;
            if (p1_v) m_rd = p1_d;
            p1_v = p0_v; p1_d = p0_d; p0_v = 1'b0;
            if (bus.vga_rd_en) begin
                m_en = 1'b1; m_we = 1'b0; m_addr = bus.vga_rd_addr;
                p0_v = 1'b1; p0_d = ref_mem[32'(bus.vga_rd_addr)];
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                m_en = 1'b1; m_we = 1'b1; m_addr = w.addr; m_wdata = w.data;
                ref_mem[32'(w.addr)] = w.data;
            end else begin
                m_en = 1'b0; m_we = 1'b0;
            end
            if (last_acc) begin
                if (32'(bus.wr_addr) < FB_DEPTH) mq.push_back('{addr: bus.wr_addr, data: bus.wr_data});
                else m_oob = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_wr(input logic v, input int a, input int d);
        bus.wr_valid = v;
        bus.wr_addr  = ADDR_W'(a);
        bus.wr_data  = DATA_W'(d);
    endtask

    initial begin
        for (int i = 0; i < FB_DEPTH; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        rst = 1'b1;
        bus.vga_rd_en = 1'b0;
        bus.vga_rd_addr = '0;
        drive_wr(1'b0, 0, 0);
        #1;

        // Reset state
        step();
        step();
        check("t1_ram_en", 32'(bus.ram_en), 0);
        check("t1_ram_we", 32'(bus.ram_we), 0);
        check("t1_wr_ready", 32'(bus.wr_ready), 1);
        check("t1_level", 32'(bus.fifo_level), 0);
        check("t1_rd_valid", 32'(bus.vga_rd_valid), 0);
        check("t1_oob", 32'(bus.oob_err), 0);
        rst = 1'b0;

        // Read priority with two writes queued
        bus.vga_rd_en = 1'b1;
        bus.vga_rd_addr = 16'h0010;
        drive_wr(1'b1, 200, 8'h11);
        step();
        drive_wr(1'b1, 201, 8'h22);
        step();
        drive_wr(1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t2_no_write", 32'(bus.ram_we), 0);
        end
        check("t2_level", 32'(bus.fifo_level), 2);
        check("t2_rd_valid", 32'(bus.vga_rd_valid), 1);
        check("t2_rd_data", 32'(bus.vga_rd_data), 32'(init_val(16)));
        bus.vga_rd_en = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Blanking write: accepted at one edge, on the RAM bus after the next
        drive_wr(1'b1, 100, 8'hA5);
        step();
        drive_wr(1'b0, 0, 0);
        check("t3_no_early_we", 32'(bus.ram_we), 0);
        step();
        check("t3_we", 32'(bus.ram_we), 1);
        check("t3_addr", 32'(bus.ram_addr), 100);
        check("t3_wdata", 32'(bus.ram_wdata), 32'h0A5);
        check("t3_level", 32'(bus.fifo_level), 0);

        // Full queue, held-off fifth write, ordered drain
        bus.vga_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_wr(1'b1, 300 + i, 8'h40 + i);
            step();
        end
        drive_wr(1'b1, 400, 8'h55);
        step();
        step();
        check("t4_full_ready", 32'(bus.wr_ready), 0);
        check("t4_full_level", 32'(bus.fifo_level), 4);
        bus.vga_rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_acc) drive_wr(1'b0, 0, 0);
            check("t4_drain_we", 32'(bus.ram_we), 1);
            check("t4_drain_addr", 32'(bus.ram_addr), (i < 4) ? 300 + i : 400);
            if (i == 0) check("t4_ready_after_pop", 32'(bus.wr_ready), 1);
        end

        // Out-of-range write
        drive_wr(1'b1, FB_DEPTH, 8'h99);
        step();
        drive_wr(1'b0, 0, 0);
        check("t5_oob", 32'(bus.oob_err), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_we", 32'(bus.ram_we), 0);
        end
        check("t5_oob_sticky", 32'(bus.oob_err), 1);

        // Reset while writes are queued
        bus.vga_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 500 + i, 8'hC0 + i);
            step();
        end
        drive_wr(1'b0, 0, 0);
        check("t6_level_before", 32'(bus.fifo_level), 3);
        bus.vga_rd_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_level_after", 32'(bus.fifo_level), 0);
        check("t6_oob_cleared", 32'(bus.oob_err), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_we", 32'(bus.ram_we), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.vga_rd_en = ($urandom_range(0, 9) < 6);
            bus.vga_rd_addr = ADDR_W'($urandom_range(0, 63));
            if (!bus.wr_valid || last_acc) begin
                if ($urandom_range(0, 19) == 0)
                    drive_wr(($urandom_range(0, 2) != 0), FB_DEPTH + $urandom_range(0, 1000), $urandom_range(0, 255));
                else
                    drive_wr(($urandom_range(0, 2) != 0), $urandom_range(0, 63), $urandom_range(0, 255));
            end
            step();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
